// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states,
// per-stage payload widths and the M/W payload field layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int W_FD = 64;
    localparam int W_DE = 133;
    localparam int W_EM = 133;
    localparam int W_MW = 133;

    // M/W packing, MSB first: instr | alu_out | dm_data | write_reg | pc4
    localparam int MW_PC4_LSB   = 0;
    localparam int MW_WREG_LSB  = 32;
    localparam int MW_DM_LSB    = 37;
    localparam int MW_ALU_LSB   = 69;
    localparam int MW_INSTR_LSB = 101;

    function automatic logic [W_MW-1:0] mw_pack(
        input logic [31:0] instr,
        input logic [31:0] alu_out,
        input logic [31:0] dm_data,
        input logic [4:0]  write_reg,
        input logic [31:0] pc4
    );
        return {instr, alu_out, dm_data, write_reg, pc4};
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit payload register with load enable; reset and clear both return it
// to the NOP payload so an empty slot always reads as a bubble.
module pipe_data_reg #(
    parameter int             W         = 133,
    parameter logic [W-1:0]   NOP_VALUE = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data_reg <= NOP_VALUE;
        end else if (load) begin
            data_reg <= d;
        end
    end

    assign q = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and NOP bubble payload whenever the stage is empty.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int           W         = 133,
    parameter logic [W-1:0] NOP_VALUE = {W{1'b0}},
    parameter int           SKID      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    pipe_state_t  state_reg, state_next;
    logic         in_fire, out_fire;
    logic         main_load, main_clear, main_from_skid;
    logic         skid_load, skid_clear;
    logic [W-1:0] main_d, main_q, skid_q;

    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_reg;
    assign out_data  = main_q;
    assign main_d    = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        // Only reachable with the skid slot present.
                        if (SKID != 0) begin
                            state_next = ST_TWO;
                            skid_load  = 1'b1;
                        end
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_next     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(
        .W         (W),
        .NOP_VALUE (NOP_VALUE)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            // Registered ready breaks the combinational path from out_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_TWO);
                end
            end

            assign in_ready = in_ready_reg;

            pipe_data_reg #(
                .W         (W),
                .NOP_VALUE (NOP_VALUE)
            ) u_skid_reg (
                .clk   (clk),
                .reset (reset),
                .clear (skid_clear),
                .load  (skid_load),
                .d     (in_data),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            logic unused_skid_ctrl;

            assign unused_skid_ctrl = skid_load | skid_clear;
            assign in_ready         = ~out_valid | out_ready;
            assign skid_q           = NOP_VALUE;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic on a
// skid build and a single-register build, checked against queue models.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int           W   = W_MW;
    localparam logic [W-1:0] NOP = {W{1'b0}};

    logic         clk = 1'b0;
    logic         reset;
    logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] in_data1, out_data1;
    logic [1:0]   occ1;
    logic         flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [W-1:0] in_data0, out_data0;
    logic [1:0]   occ0;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference models: a stage is an ordered queue of in-flight payloads.
    logic [W-1:0] mq1[$];
    logic [W-1:0] mq0[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.W(W), .NOP_VALUE(NOP), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_skid #(.W(W), .NOP_VALUE(NOP), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    // Upstream must hold a stalled offer steady.
    logic         hold1_q = 1'b0, hold0_q = 1'b0;
    logic [W-1:0] data1_q, data0_q;
    always @(posedge clk) begin
        if (hold1_q) assert (in_valid1 && in_data1 == data1_q) else $error("upstream offer changed while stalled (skid build)");
        if (hold0_q) assert (in_valid0 && in_data0 == data0_q) else $error("upstream offer changed while stalled (single build)");
        hold1_q <= in_valid1 && !in_ready1 && !reset && !flush1;
        hold0_q <= in_valid0 && !in_ready0 && !reset && !flush0;
        data1_q <= in_data1;
        data0_q <= in_data0;
    end

    function automatic logic [W-1:0] rand_payload();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Advance one clock and update both queue models from the handshake rules.
    task automatic tick();
        bit of1, if1, of0, if0;
        of1 = (mq1.size() != 0) && out_ready1;
        if1 = in_valid1 && (mq1.size() < 2);
        of0 = (mq0.size() != 0) && out_ready0;
        if0 = in_valid0 && (mq0.size() == 0 || out_ready0);
        @(posedge clk);
        if (reset || flush1) mq1.delete();
        else begin
            if (of1) void'(mq1.pop_front());
            if (if1) mq1.push_back(in_data1);
        end
        if (reset || flush0) mq0.delete();
        else begin
            if (of0) void'(mq0.pop_front());
            if (if0) mq0.push_back(in_data0);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid1 = 1'b1; in_data1 = 133'h1; out_ready1 = 1'b0;
        tick(); tick();
        reset = 1'b0; in_valid1 = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
        tests_run++; if (out_data1 !== NOP) begin tests_failed++; $display("FAIL reset_out_data: got %h want %h", out_data1, NOP); end
        tests_run++; if (occ1 !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", occ1); end
        tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
        tests_run++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin tests_failed++; $display("FAIL reset_single: got ready %b valid %b want 1 0", in_ready0, out_valid0); end
        $display("[TB] reset: checked idle outputs after release");
        tick();
    endtask

    task automatic test_streaming();
        out_ready1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid1 = (i < 3);
            in_data1  = (i < 3) ? W'(8'h10 + i) : NOP;
            @(negedge clk);
            if (i < 3) begin
                tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready %0d: got %b want 1", i, in_ready1); end
            end
            if (i >= 1 && i <= 3) begin
                tests_run++;
                if (out_valid1 !== 1'b1 || out_data1 !== W'(8'h10 + i - 1)) begin
                    tests_failed++; $display("FAIL stream_out %0d: got valid %b data %h want 1 %h", i, out_valid1, out_data1, W'(8'h10 + i - 1));
                end
            end
            if (i == 4) begin
                tests_run++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin tests_failed++; $display("FAIL stream_drained: got valid %b data %h want 0 %h", out_valid1, out_data1, NOP); end
            end
            $display("[TB] stream cycle %0d: out_valid=%b out_data=%h", i, out_valid1, out_data1);
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = W'(8'hA);
        tick();
        in_data1 = W'(8'hB);
        @(negedge clk);
        tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_one: got %b want 1", in_ready1); end
        tick();
        in_valid1 = 1'b0;
        @(negedge clk);
        tests_run++; if (occ1 !== 2'd2) begin tests_failed++; $display("FAIL bp_occupancy: got %0d want 2", occ1); end
        tests_run++; if (in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full: got %b want 0", in_ready1); end
        tests_run++; if (out_valid1 !== 1'b1 || out_data1 !== W'(8'hA)) begin tests_failed++; $display("FAIL bp_head: got valid %b data %h want 1 a", out_valid1, out_data1); end
        tick();
        out_ready1 = 1'b1;
        @(negedge clk);
        tests_run++; if (out_data1 !== W'(8'hA) || in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL bp_stall_hold: got data %h ready %b want a 0", out_data1, in_ready1); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid1 !== 1'b1 || out_data1 !== W'(8'hB)) begin tests_failed++; $display("FAIL bp_second: got valid %b data %h want 1 b", out_valid1, out_data1); end
        tests_run++; if (in_ready1 !== 1'b1 || occ1 !== 2'd1) begin tests_failed++; $display("FAIL bp_ready_back: got ready %b occ %0d want 1 1", in_ready1, occ1); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin tests_failed++; $display("FAIL bp_drained: got valid %b data %h want 0 %h", out_valid1, out_data1, NOP); end
        $display("[TB] backpressure: a then b delivered, stage drained");
        tick();
    endtask

    task automatic test_flush_two();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = W'(8'hA);
        tick();
        in_data1 = W'(8'hB);
        tick();
        in_valid1 = 1'b0; flush1 = 1'b1;
        @(negedge clk);
        tests_run++; if (occ1 !== 2'd2) begin tests_failed++; $display("FAIL flush2_pre_occ: got %0d want 2", occ1); end
        tick();
        flush1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid1 !== 1'b0 || out_data1 !== NOP || occ1 !== 2'd0 || in_ready1 !== 1'b1) begin
                tests_failed++; $display("FAIL flush2_empty %0d: got valid %b data %h occ %0d ready %b want 0 0 0 1", i, out_valid1, out_data1, occ1, in_ready1);
            end
            tick();
        end
        $display("[TB] flush in TWO: stage empty, no stale entries emitted");
    endtask

    task automatic test_flush_in_fire();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = W'(8'h5);
        tick();
        in_data1 = W'(8'h6); flush1 = 1'b1;
        @(negedge clk);
        tests_run++; if (in_ready1 !== 1'b1 || out_data1 !== W'(8'h5)) begin tests_failed++; $display("FAIL flushfire_pre: got ready %b data %h want 1 5", in_ready1, out_data1); end
        tick();
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin
                tests_failed++; $display("FAIL flushfire_empty %0d: got valid %b data %h want 0 %h", i, out_valid1, out_data1, NOP);
            end
            tick();
        end
        $display("[TB] flush with in_fire: entry 6 discarded");
    endtask

    task automatic test_single_reg();
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = W'(8'h7);
        @(negedge clk);
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL single_ready_empty: got %b want 1", in_ready0); end
        tick();
        in_data0 = W'(8'h8);
        @(negedge clk);
        tests_run++; if (in_ready0 !== 1'b0 || occ0 !== 2'd1 || out_data0 !== W'(8'h7)) begin tests_failed++; $display("FAIL single_stall: got ready %b occ %0d data %h want 0 1 7", in_ready0, occ0, out_data0); end
        tick();
        out_ready0 = 1'b1;
        #1;
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL single_comb_ready: got %b want 1", in_ready0); end
        @(negedge clk);
        tests_run++; if (out_data0 !== W'(8'h7)) begin tests_failed++; $display("FAIL single_hold: got %h want 7", out_data0); end
        tick();
        in_valid0 = 1'b0;
        @(negedge clk);
        tests_run++; if (out_data0 !== W'(8'h8) || occ0 !== 2'd1) begin tests_failed++; $display("FAIL single_replace: got data %h occ %0d want 8 1", out_data0, occ0); end
        tick();
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0 || occ0 !== 2'd0) begin tests_failed++; $display("FAIL single_drained: got valid %b occ %0d want 0 0", out_valid0, occ0); end
        $display("[TB] single register: combinational ready, replacement accepted");
        tick();
    endtask

    task automatic test_random_skid(int n);
        bit           hold;
        logic         exp_v, exp_r;
        logic [1:0]   exp_o;
        logic [W-1:0] exp_d;
        hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            flush1     = ($urandom_range(0, 19) == 0);
            out_ready1 = ($urandom_range(0, 2) != 0);
            if (!hold) begin in_valid1 = $urandom_range(0, 1) == 1; in_data1 = rand_payload(); end
            exp_r = (mq1.size() < 2);
            exp_v = (mq1.size() != 0);
            exp_d = exp_v ? mq1[0] : NOP;
            exp_o = 2'(mq1.size());
            hold  = in_valid1 && !exp_r && !flush1 && !reset;
            @(negedge clk);
            tests_run++; if (out_valid1 !== exp_v) begin tests_failed++; $display("FAIL rand_skid_valid %0d: got %b want %b", i, out_valid1, exp_v); end
            tests_run++; if (out_data1 !== exp_d) begin tests_failed++; $display("FAIL rand_skid_data %0d: got %h want %h", i, out_data1, exp_d); end
            tests_run++; if (in_ready1 !== exp_r) begin tests_failed++; $display("FAIL rand_skid_ready %0d: got %b want %b", i, in_ready1, exp_r); end
            tests_run++; if (occ1 !== exp_o) begin tests_failed++; $display("FAIL rand_skid_occ %0d: got %0d want %0d", i, occ1, exp_o); end
            tick();
        end
        reset = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0;
        tick();
        $display("[TB] random skid build: %0d cycles", n);
    endtask

    task automatic test_random_single(int n);
        bit           hold;
        logic         exp_v, exp_r;
        logic [1:0]   exp_o;
        logic [W-1:0] exp_d;
        hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            flush0     = ($urandom_range(0, 19) == 0);
            out_ready0 = ($urandom_range(0, 2) != 0);
            if (!hold) begin in_valid0 = $urandom_range(0, 1) == 1; in_data0 = rand_payload(); end
            exp_r = (mq0.size() == 0) || out_ready0;
            exp_v = (mq0.size() != 0);
            exp_d = exp_v ? mq0[0] : NOP;
            exp_o = 2'(mq0.size());
            hold  = in_valid0 && !exp_r && !flush0 && !reset;
            @(negedge clk);
            tests_run++; if (out_valid0 !== exp_v) begin tests_failed++; $display("FAIL rand_single_valid %0d: got %b want %b", i, out_valid0, exp_v); end
            tests_run++; if (out_data0 !== exp_d) begin tests_failed++; $display("FAIL rand_single_data %0d: got %h want %h", i, out_data0, exp_d); end
            tests_run++; if (in_ready0 !== exp_r) begin tests_failed++; $display("FAIL rand_single_ready %0d: got %b want %b", i, in_ready0, exp_r); end
            tests_run++; if (occ0 !== exp_o) begin tests_failed++; $display("FAIL rand_single_occ %0d: got %0d want %0d", i, occ0, exp_o); end
            tick();
        end
        reset = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0;
        tick();
        $display("[TB] random single build: %0d cycles", n);
    endtask

    initial begin
        reset = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = NOP; out_ready1 = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = NOP; out_ready0 = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_flush_in_fire();
        test_single_reg();
        test_random_skid(400);
        test_random_single(400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed MEM/WB-style stage register; one instance sits between any two pipeline stages (F/D, D/E, E/M, M/W).
- Carries an opaque W-bit payload, which is the packed fields of the stage.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for registered backpressure, a synchronous flush, and bubble insertion of a programmable NOP payload.

Parameters:
- W, 133, payload width (M/W packing: instr 32 + alu_out 32 + dm_data 32 + write_reg 5 + pc4 32).
- NOP_VALUE, {W{1'b0}}, payload driven and stored whenever the stage holds no valid entry.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous kill of all stage contents
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage accepts entry this cycle
- in_data  input  W  upstream payload
- out_valid  output  1  stage presents entry
- out_ready  input  1  downstream accepts entry
- out_data  output  W  payload presented downstream
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - Payloads transfer only on fire.
- Storage: main_reg (W bits) drives out_data. When SKID=1, there is also skid_reg (W bits).
- States (SKID=1): EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO), taken from a register with no combinational path from out_ready.
- Transitions (SKID=1), flush/reset absent:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire & !out_fire -> TWO, skid <= in_data. !in_fire & out_fire -> EMPTY, main <= NOP_VALUE. Neither -> hold.
  - TWO: out_fire -> ONE, main <= skid, skid <= NOP_VALUE. Otherwise hold. in_ready = 0, so there is no in_fire in this state.
- SKID=0:
  - States are EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire & out_fire in ONE stays in ONE with the new payload.
- Bubble rule: whenever out_valid = 0, out_data == NOP_VALUE. Downstream decodes this as a nop.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush:
  - Next state EMPTY, main/skid <= NOP_VALUE, occupancy 0, regardless of state.
  - Flush overrides a same-cycle in_fire; that entry is discarded, but upstream still sees in_ready as asserted that cycle.
  - A same-cycle out_fire is still consumed by downstream; flush does not gate out_valid in the current cycle.
- Reset:
  - Same effect as flush.
  - Outputs after reset: out_valid 0, out_data NOP_VALUE, occupancy 0, in_ready 1.
  - Reset mid-operation discards both entries.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle in steady state with out_ready held high.
- Stall: holding out_ready = 0 keeps out_data and out_valid stable. This is the AXI-style rule: a presented entry never changes or drops until fire or flush.
- Upstream protocol expectation (checked by bench assertion): in_valid & in_data stay stable while in_valid & !in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - the state localparams ST_EMPTY, ST_ONE, ST_TWO (2-bit encoding);
  - the per-stage payload widths (W_FD, W_DE, W_EM, W_MW = 133);
  - the field offsets for packing and unpacking the M/W payload.
- One natural sub-module, pipe_data_reg: a W-bit register with load enable, a synchronous clear-to-NOP_VALUE, and reset. It is instantiated for main_reg and, under a generate on SKID, for skid_reg.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_data=0x1 -> out_valid=0, out_data=NOP_VALUE (0), occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1, push 0x10,0x11,0x12 back-to-back -> out_data 0x10,0x11,0x12 on consecutive cycles, each 1 cycle after its in_fire; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered in order, and in_ready returns to 1 the cycle after the first out_fire.
- Flush in TWO: fill with 0xA and 0xB, assert flush together with out_ready=0 -> next cycle out_valid=0, out_data=0, occupancy=0. Neither 0xA nor 0xB appears afterwards.
- Flush with simultaneous in_fire: stage in ONE holding 0x5, in_valid=1 with 0x6, flush=1 -> next cycle EMPTY and 0x6 never emitted.
- SKID=0 build: out_ready=0 while in ONE -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 combinationally, replacement accepted, and occupancy never exceeds 1.
